// File: rtl/scoreboard_page_sequencer.sv
// Scoreboard page sequencer: cycles through the game statistics one page at a
// time, snapshots the selected value for the digit decomposer and strobes
// page_load when a new page's value is first presented.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | display disabled, all outputs cleared, waiting for en
//   LOAD   | one cycle: capture the new page's value, clear the dwell timer
//   SHOW   | page on display; value tracks its source unless held; dwell runs
module scoreboard_page_sequencer #(
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int VAL_W        = 21,
    parameter int NUM_PAGES    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [VAL_W-1:0] combo,
    input  logic [VAL_W-1:0] base_score,
    input  logic [VAL_W-1:0] bonus_score,
    input  logic [VAL_W-1:0] acc,
    input  logic [1:0]       mod,
    input  logic [3:0]       difficulty,
    input  logic [2:0]       level,
    input  logic             btn_next,
    input  logic             btn_hold,
    output logic [2:0]       page_idx,
    output logic [VAL_W-1:0] page_val,
    output logic             page_load,
    output logic             busy
);

    localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [2:0]    LAST_PAGE  = 3'(NUM_PAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        page_idx_q, page_idx_d;
    logic [VAL_W-1:0]  page_val_q, page_val_d;
    logic              page_load_q, page_load_d;
    logic              busy_q, busy_d;
    logic [DW-1:0]     dwell_q, dwell_d;

    logic [VAL_W-1:0]  sel_val;
    logic              expire;
    logic              advance;

    // Select the statistic for the current page, zero-extending narrow sources.
    always_comb begin
        sel_val = '0;
        case (page_idx_q)
            3'd0:    sel_val = combo;
            3'd1:    sel_val = base_score;
            3'd2:    sel_val = bonus_score;
            3'd3:    sel_val = acc;
            3'd4:    sel_val = VAL_W'(mod);
            3'd5:    sel_val = VAL_W'(difficulty);
            3'd6:    sel_val = VAL_W'(level);
            default: sel_val = '0;
        endcase
    end

    // Auto-advance needs the timer running; a manual pulse advances regardless of hold.
    assign expire  = !btn_hold && (dwell_q == DWELL_LAST);
    assign advance = btn_next || expire;

    // Next-state and next-output logic for the page FSM.
    always_comb begin
        state_d     = state_q;
        page_idx_d  = page_idx_q;
        page_val_d  = page_val_q;
        page_load_d = 1'b0;
        dwell_d     = dwell_q;

        if (!en) begin
            state_d    = S_IDLE;
            page_idx_d = '0;
            page_val_d = '0;
            dwell_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_LOAD;
                    page_idx_d = '0;
                end
                S_LOAD: begin
                    page_val_d  = sel_val;
                    page_load_d = 1'b1;
                    dwell_d     = '0;
                    state_d     = S_SHOW;
                end
                S_SHOW: begin
                    if (!btn_hold) begin
                        page_val_d = sel_val;
                        dwell_d    = dwell_q + DW'(1);
                    end
                    if (advance) begin
                        page_idx_d = (page_idx_q == LAST_PAGE) ? 3'd0 : page_idx_q + 3'd1;
                        dwell_d    = '0;
                        state_d    = S_LOAD;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    page_idx_d = '0;
                    page_val_d = '0;
                    dwell_d    = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            page_idx_q  <= '0;
            page_val_q  <= '0;
            page_load_q <= 1'b0;
            busy_q      <= 1'b0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            page_idx_q  <= page_idx_d;
            page_val_q  <= page_val_d;
            page_load_q <= page_load_d;
            busy_q      <= busy_d;
            dwell_q     <= dwell_d;
        end
    end

    assign page_idx  = page_idx_q;
    assign page_val  = page_val_q;
    assign page_load = page_load_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scoreboard_page_sequencer.sv
// Directed bench for scoreboard_page_sequencer with a short dwell time.
module tb_scoreboard_page_sequencer;

    localparam int DWELL = 4;
    localparam int VW    = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [VW-1:0] combo, base_score, bonus_score, acc;
    logic [1:0]    mod;
    logic [3:0]    difficulty;
    logic [2:0]    level;
    logic          btn_next, btn_hold;
    logic [2:0]    page_idx;
    logic [VW-1:0] page_val;
    logic          page_load;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    scoreboard_page_sequencer #(
        .DWELL_CYCLES(DWELL),
        .VAL_W       (VW),
        .NUM_PAGES   (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .combo      (combo),
        .base_score (base_score),
        .bonus_score(bonus_score),
        .acc        (acc),
        .mod        (mod),
        .difficulty (difficulty),
        .level      (level),
        .btn_next   (btn_next),
        .btn_hold   (btn_hold),
        .page_idx   (page_idx),
        .page_val   (page_val),
        .page_load  (page_load),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_idx"},  int'(page_idx), 0);
        chk({tag, "_val"},  int'(page_val), 0);
        chk({tag, "_load"}, int'(page_load), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    int exp_idx [6] = '{2, 3, 4, 5, 6, 0};
    int exp_val [6] = '{777, 88, 2, 9, 5, 123};

    initial begin
        int prev;
        rst = 1'b1; en = 1'b0; btn_next = 1'b0; btn_hold = 1'b0;
        combo = 21'd123; base_score = 21'd5000; bonus_score = 21'd777;
        acc = 21'd88; mod = 2'd2; difficulty = 4'd9; level = 3'd5;

        // Reset
        step(); step();
        chk_cleared("reset");
        rst = 1'b0;

        // Start-up
        en = 1'b1;
        step();
        chk("start_c1_idx", int'(page_idx), 0);
        chk("start_c1_busy", int'(busy), 1);
        chk("start_c1_load", int'(page_load), 0);
        step();
        chk("start_c2_load", int'(page_load), 1);
        chk("start_c2_val", int'(page_val), 123);
        step();
        chk("start_c3_load", int'(page_load), 0);

        // Auto-advance: SHOW dwell 0..3 then LOAD
        step(); step();
        chk("auto_c5_idx", int'(page_idx), 0);
        step();
        chk("auto_load_idx", int'(page_idx), 1);
        chk("auto_load_busy", int'(busy), 1);
        step();
        chk("auto_page1_val", int'(page_val), 5000);
        chk("auto_page1_load", int'(page_load), 1);

        // Remaining pages and wrap: 4 SHOW + 1 LOAD per page
        prev = 1;
        for (int p = 0; p < 6; p++) begin
            step(); step(); step();
            chk("dwell_hold_idx", int'(page_idx), prev);
            step();
            chk("dwell_next_idx", int'(page_idx), exp_idx[p]);
            step();
            chk("page_val", int'(page_val), exp_val[p]);
            chk("page_load", int'(page_load), 1);
            prev = exp_idx[p];
        end

        // Manual advance on first SHOW cycle of page 0
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        chk("manual_idx", int'(page_idx), 1);
        // btn_next during LOAD is ignored
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        chk("load_ignore_idx", int'(page_idx), 1);
        chk("load_ignore_load", int'(page_load), 1);
        chk("load_ignore_val", int'(page_val), 5000);
        step();
        chk("load_ignore_idx2", int'(page_idx), 1);
        chk("load_ignore_load2", int'(page_load), 0);

        // btn_next coincident with expiry: single advance
        step(); step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        chk("coinc_idx", int'(page_idx), 2);
        step();
        chk("coinc_idx2", int'(page_idx), 2);
        chk("coinc_val", int'(page_val), 777);
        step();
        chk("coinc_idx3", int'(page_idx), 2);

        // Abort with en=0 mid-SHOW on page 3
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        step();
        chk("p3_val", int'(page_val), 88);
        step();
        chk("p3_idx", int'(page_idx), 3);
        en = 1'b0;
        step();
        chk_cleared("en_abort");

        // rst during LOAD of page 1
        en = 1'b1;
        step(); step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        chk("pre_rst_idx", int'(page_idx), 1);
        rst = 1'b1;
        step();
        chk_cleared("rst_abort");
        rst = 1'b0;
        step();
        chk("restart_idx", int'(page_idx), 0);
        chk("restart_busy", int'(busy), 1);
        step();
        chk("restart_val", int'(page_val), 123);
        chk("restart_load", int'(page_load), 1);

        // Hold after 2 SHOW cycles
        step(); step();
        btn_hold = 1'b1;
        combo = 21'd124;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_val", int'(page_val), 123);
            chk("hold_idx", int'(page_idx), 0);
        end
        btn_hold = 1'b0;
        step();
        chk("release_val", int'(page_val), 124);
        chk("release_idx", int'(page_idx), 0);
        step();
        chk("release_adv_idx", int'(page_idx), 1);

        // btn_next still advances while held
        step();
        chk("held_p1_val", int'(page_val), 5000);
        btn_hold = 1'b1;
        step(); step(); step(); step(); step();
        chk("held_no_auto_idx", int'(page_idx), 1);
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        btn_hold = 1'b0;
        chk("held_next_idx", int'(page_idx), 2);
        step();
        chk("held_next_val", int'(page_val), 777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scoreboard_page_sequencer.md
Name: scoreboard_page_sequencer

Overview:
- Selects which game statistic the scoreboard shows and when, then snapshots that value for the digit decomposer.
- Steps through 7 pages in order: combo, base_score, bonus_score, acc, mod, difficulty, level.
- Advances on a dwell timer or on a manual next pulse; a hold input freezes both the timer and the shown value.
- Sits between the game-state registers and the display/decompose path.

Parameters:
- DWELL_CYCLES, 25_000_000: SHOW cycles per page before auto-advance (minimum 2).
- VAL_W, 21: width of the statistic and output value.
- NUM_PAGES, 7: page count; the wrap point is NUM_PAGES-1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; low forces IDLE.
- combo  in  21  current combo.
- base_score  in  21  base score.
- bonus_score  in  21  bonus score.
- acc  in  21  accuracy.
- mod  in  2  active mod.
- difficulty  in  4  difficulty.
- level  in  3  level.
- btn_next  in  1  single-cycle pulse from the debounced button; request next page.
- btn_hold  in  1  level; freeze page timer and value.
- page_idx  out  3  current page, 0..6.
- page_val  out  21  snapshot of the selected statistic, zero-extended.
- page_load  out  1  one-cycle strobe when a new page's value is first presented.
- busy  out  1  high in LOAD and SHOW.

Behaviour:
- Reset (rst=1 at a posedge, highest priority):
  - state=IDLE, page_idx=0, page_val=0, page_load=0, busy=0, dwell counter=0.
- Source mux (by page_idx): 0 combo, 1 base_score, 2 bonus_score, 3 acc, 4 mod, 5 difficulty, 6 level.
  - Narrow sources are zero-extended to VAL_W.
  - page_idx 7 is unreachable; if it ever occurs it selects 0.
- IDLE:
  - Outputs held at reset values.
  - en=1 → LOAD, with page_idx=0.
- LOAD (exactly one cycle, btn_next ignored):
  - page_val ← mux(page_idx); page_load ← 1; dwell counter ← 0; next state SHOW.
  - page_load is therefore high during the first SHOW cycle only.
- SHOW, every cycle:
  - page_load=0.
  - If btn_hold=0: page_val ← mux(page_idx) (live tracking) and the dwell counter increments.
  - If btn_hold=1: page_val and the dwell counter hold their values.
- Advance, from SHOW only:
  - Condition: btn_next=1, OR (btn_hold=0 AND dwell==DWELL_CYCLES-1).
  - Action: page_idx ← (page_idx==NUM_PAGES-1) ? 0 : page_idx+1; state ← LOAD.
  - btn_next still advances while btn_hold=1; hold blocks only the auto-advance and value updates.
  - btn_next coincident with expiry → a single advance.
- Latency:
  - Advance condition at cycle N → page_idx updates at N+1.
  - page_val and page_load=1 appear at N+2.
- en=0 in any state → IDLE on the next edge, with all outputs cleared as in reset. Re-enabling restarts at page 0.
- rst mid-LOAD or mid-SHOW: same as en=0; no partial page survives.
- Dwell counter width is ceil(log2(DWELL_CYCLES)) bits; it never exceeds DWELL_CYCLES-1.
- busy = (state != IDLE), registered.

Test Plan:
- Start-up: rst 2 cycles, then en=1 at cycle 0 with combo=123 → cycle 1 page_idx=0, busy=1; cycle 2 page_load=1, page_val=123; cycle 3 page_load=0.
- Auto-advance (DWELL_CYCLES=4, base_score=5000) → after 4 SHOW cycles page_idx=1, then page_val=5000 with a page_load pulse. Every page gets 4 SHOW + 1 LOAD cycles.
- Wrap (DWELL_CYCLES=4, level=5, difficulty=9) → page 5 shows 9, page 6 shows 5, and the next advance gives page_idx=0 with page_val=combo.
- Manual and coincident: btn_next on SHOW cycle 1 → page advances immediately. btn_next on the expiry cycle → page_idx increases by exactly 1. btn_next during the LOAD cycle → ignored.
- Hold (DWELL_CYCLES=4): btn_hold=1 after 2 SHOW cycles for 20 cycles, combo 123→124 → page_val stays 123 and page_idx unchanged. btn_next during hold → advances. After release: page_val=124 one cycle later, and the advance comes after the remaining 2 cycles.
- Abort: en=0 mid-SHOW on page 3 → next cycle page_idx=0, page_val=0, busy=0. rst asserted during LOAD → same cleared state; re-enable restarts at page 0.
